// File: rtl/vc_arbiter_reader.sv
// vc_arbiter_reader: pops VC0/VC1 by strict priority with bounded VC1 starvation and
// routes each popped word to D0/D1 by its class bit. Define VC_ARB_STATS_EN for forward counters.
module vc_arbiter_reader #(
  parameter int DATA_WIDTH   = 6,
  parameter int DEST_BIT     = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic                  empty_VC0,
  input  logic                  empty_VC1,
  input  logic [DATA_WIDTH-1:0] data_VC0,
  input  logic [DATA_WIDTH-1:0] data_VC1,
  input  logic                  almost_full_D0,
  input  logic                  almost_full_D1,
  input  logic                  full_D0,
  input  logic                  full_D1,
  output logic                  pop_VC0,
  output logic                  pop_VC1,
  output logic                  push_D0,
  output logic                  push_D1,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  idle
`ifdef VC_ARB_STATS_EN
  ,
  output logic [7:0]            fwd_cnt_VC0,
  output logic [7:0]            fwd_cnt_VC1
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_STALL  = 2'd2
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t                state_reg, state_next;
  logic [3:0]            starve_reg;
  logic                  stall;
  logic                  pop0, pop1;
  logic                  pend_reg;
  logic                  pend_vc_reg;
  logic [DATA_WIDTH-1:0] word;
  logic                  deliver;

  assign stall = almost_full_D0 | almost_full_D1 | full_D0 | full_D1;

  // Pops are gated by the live empty flags so a single remaining entry is read once.
  always_comb begin
    state_next = state_reg;
    pop0       = 1'b0;
    pop1       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (init) state_next = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (!init)       state_next = ST_IDLE;
        else if (stall)  state_next = ST_STALL;
        else if (!empty_VC1 && (empty_VC0 || starve_reg == LIMIT)) pop1 = 1'b1;
        else if (!empty_VC0) pop0 = 1'b1;
      end
      ST_STALL: begin
        if (!init)       state_next = ST_IDLE;
        else if (!stall) state_next = ST_ACTIVE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign pop_VC0 = pop0;
  assign pop_VC1 = pop1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_reg <= 4'd0;
    end else if (!init || pop1 || (pop0 && empty_VC1)) begin
      starve_reg <= 4'd0;
    end else if (pop0 && starve_reg != LIMIT) begin
      starve_reg <= starve_reg + 4'd1;
    end
  end

  // The FIFO read data arrives one cycle after the pop; pend_* tracks which VC it came from.
  assign word    = pend_vc_reg ? data_VC1 : data_VC0;
  assign deliver = pend_reg & init;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_reg    <= 1'b0;
      pend_vc_reg <= 1'b0;
      push_D0     <= 1'b0;
      push_D1     <= 1'b0;
      data_out    <= '0;
      idle        <= 1'b1;
    end else begin
      pend_reg    <= pop0 | pop1;
      pend_vc_reg <= pop1;
      push_D0     <= deliver & ~word[DEST_BIT];
      push_D1     <= deliver &  word[DEST_BIT];
      if (deliver) data_out <= word;
      idle        <= empty_VC0 & empty_VC1 & ~pend_reg;
    end
  end

`ifdef VC_ARB_STATS_EN
  logic [7:0] fwd0_reg, fwd1_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fwd0_reg <= 8'd0;
      fwd1_reg <= 8'd0;
    end else if (!init) begin
      fwd0_reg <= 8'd0;
      fwd1_reg <= 8'd0;
    end else if (pend_reg) begin
      if (pend_vc_reg) fwd1_reg <= fwd1_reg + 8'd1;
      else             fwd0_reg <= fwd0_reg + 8'd1;
    end
  end

  assign fwd_cnt_VC0 = fwd0_reg;
  assign fwd_cnt_VC1 = fwd1_reg;
`endif

endmodule

// File: tb/tb_vc_arbiter_reader.sv
// tb_vc_arbiter_reader: FIFO models feed the reader; a scoreboard queue holds expected
// pushes (word, source VC, due cycle) and is checked whenever the reader pushes.
`timescale 1ns/100ps
module tb_vc_arbiter_reader;
  localparam int DW = 6;
  localparam int DB = 4;
  localparam int SL = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          init;
  logic          empty_VC0 = 1'b1;
  logic          empty_VC1 = 1'b1;
  logic [DW-1:0] data_VC0 = '0;
  logic [DW-1:0] data_VC1 = '0;
  logic          almost_full_D0, almost_full_D1, full_D0, full_D1;
  logic          pop_VC0, pop_VC1, push_D0, push_D1, idle;
  logic [DW-1:0] data_out;
`ifdef VC_ARB_STATS_EN
  logic [7:0]    fwd_cnt_VC0, fwd_cnt_VC1;
  int            fwd_e0 = 0;
  int            fwd_e1 = 0;
`endif

  vc_arbiter_reader #(.DATA_WIDTH(DW), .DEST_BIT(DB), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .reset(reset), .init(init),
    .empty_VC0(empty_VC0), .empty_VC1(empty_VC1),
    .data_VC0(data_VC0), .data_VC1(data_VC1),
    .almost_full_D0(almost_full_D0), .almost_full_D1(almost_full_D1),
    .full_D0(full_D0), .full_D1(full_D1),
    .pop_VC0(pop_VC0), .pop_VC1(pop_VC1),
    .push_D0(push_D0), .push_D1(push_D1),
    .data_out(data_out), .idle(idle)
`ifdef VC_ARB_STATS_EN
    , .fwd_cnt_VC0(fwd_cnt_VC0), .fwd_cnt_VC1(fwd_cnt_VC1)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] word;
    logic          vc;
    int            due;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  int            pop_log[$];
  int            pop_cyc[$];
  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  int            push_cnt = 0;
  logic          p0_s = 1'b0;
  logic          p1_s = 1'b0;
  logic          init_s = 1'b0;
  logic          pend_v = 1'b0;
  logic [DW-1:0] pend_w = '0;
  logic          pend_vc = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Sample combinational pops mid-cycle, after the stimulus has settled.
  always begin
    @(negedge clk);
    #2;
    p0_s   = pop_VC0;
    p1_s   = pop_VC1;
    init_s = init;
  end

  // VC FIFO models (read data registered one cycle after the pop) and expected-push generation.
  always @(posedge clk) begin
    logic [DW-1:0] w;
    cyc++;
    if (!reset) begin
      pend_v = 1'b0;
`ifdef VC_ARB_STATS_EN
      fwd_e0 = 0;
      fwd_e1 = 0;
`endif
    end else begin
`ifdef VC_ARB_STATS_EN
      if (!init_s) begin
        fwd_e0 = 0;
        fwd_e1 = 0;
      end
`endif
      if (pend_v && init_s) exp_q.push_back('{word: pend_w, vc: pend_vc, due: cyc});
      pend_v = 1'b0;
      if (p0_s && p1_s) check_eq("one_pop", 32'(p0_s & p1_s), 32'd0);
      if (p0_s) begin
        if (q0.size() == 0) check_eq("underflow_vc0", 32'(q0.size()), 32'd1);
        else begin
          w = q0.pop_front();
          data_VC0 <= w;
          pend_v = 1'b1; pend_w = w; pend_vc = 1'b0;
          pop_log.push_back(0); pop_cyc.push_back(cyc);
        end
      end else if (p1_s) begin
        if (q1.size() == 0) check_eq("underflow_vc1", 32'(q1.size()), 32'd1);
        else begin
          w = q1.pop_front();
          data_VC1 <= w;
          pend_v = 1'b1; pend_w = w; pend_vc = 1'b1;
          pop_log.push_back(1); pop_cyc.push_back(cyc);
        end
      end
    end
    empty_VC0 <= (q0.size() == 0);
    empty_VC1 <= (q1.size() == 0);
  end

  // Output monitor: every push is matched against the head of the scoreboard.
  always begin
    exp_t e;
    logic b1, b0;
    @(negedge clk);
    #1;
    if (reset) begin
      while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        check_eq("missing_push", 32'(cyc), 32'(exp_q[0].due));
        void'(exp_q.pop_front());
      end
      if (push_D0 || push_D1) begin
        push_cnt++;
        if (exp_q.size() == 0) begin
          check_eq("extra_push", {30'd0, push_D1, push_D0}, 32'd0);
        end else begin
          e  = exp_q.pop_front();
          b1 = e.word[DB];
          b0 = ~b1;
          check_eq("data", 32'(data_out), 32'(e.word));
          check_eq("route_d1", 32'(push_D1), 32'(b1));
          check_eq("route_d0", 32'(push_D0), 32'(b0));
          check_eq("latency", 32'(cyc), 32'(e.due));
`ifdef VC_ARB_STATS_EN
          if (e.vc) fwd_e1 = (fwd_e1 + 1) % 256;
          else      fwd_e0 = (fwd_e0 + 1) % 256;
          check_eq("fwd_cnt_vc0", 32'(fwd_cnt_VC0), 32'(fwd_e0));
          check_eq("fwd_cnt_vc1", 32'(fwd_cnt_VC1), 32'(fwd_e1));
`endif
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drain(input int budget);
    int quiet = 0;
    for (int i = 0; i < budget && quiet < 4; i++) begin
      tick(1);
      if (q0.size() == 0 && q1.size() == 0 && exp_q.size() == 0 && !pend_v &&
          !push_D0 && !push_D1 && empty_VC0 && empty_VC1) quiet++;
      else quiet = 0;
    end
    check_eq("drain", 32'(quiet >= 4 ? 1 : 0), 32'd1);
  endtask

  task automatic clear_logs();
    pop_log.delete();
    pop_cyc.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int pc;
    int found;
    int order2[12] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0};
    int order5[6]  = '{0, 0, 0, 0, 1, 0};

    reset = 1'b0; init = 1'b0;
    almost_full_D0 = 1'b0; almost_full_D1 = 1'b0; full_D0 = 1'b0; full_D1 = 1'b0;
    tick(2);
    check_eq("rst_push_d0", 32'(push_D0), 32'd0);
    check_eq("rst_push_d1", 32'(push_D1), 32'd0);
    check_eq("rst_data", 32'(data_out), 32'd0);
    check_eq("rst_idle", 32'(idle), 32'd1);
    check_eq("rst_pops", {30'd0, pop_VC1, pop_VC0}, 32'd0);
    reset = 1'b1;
    tick(2);

    // Basic route: two VC0 words, class 0 then class 1.
    clear_logs();
    pc = push_cnt;
    q0.push_back(6'h05); q0.push_back(6'h15);
    init = 1'b1;
    wait_drain(40);
    check_eq("basic_pops", 32'(pop_log.size()), 32'd2);
    if (pop_cyc.size() == 2) check_eq("basic_b2b", 32'(pop_cyc[1] - pop_cyc[0]), 32'd1);
    check_eq("basic_pushes", 32'(push_cnt - pc), 32'd2);
    check_eq("basic_idle", 32'(idle), 32'd1);

    // Starvation bound: VC1 gets a slot after every SL VC0 grants.
    clear_logs();
    for (int i = 0; i < 10; i++) q0.push_back(6'((i * 9 + 1) % 64));
    q1.push_back(6'h2C); q1.push_back(6'h13);
    wait_drain(80);
    check_eq("starve_len", 32'(pop_log.size()), 32'd12);
    for (int i = 0; i < 12 && i < pop_log.size(); i++)
      check_eq($sformatf("starve_order%0d", i), 32'(pop_log[i]), 32'(order2[i]));

    // Backpressure during a continuous VC0 stream.
    clear_logs();
    pc = push_cnt;
    for (int i = 0; i < 12; i++) q0.push_back(6'((i * 11 + 5) % 64));
    tick(5);
    found = push_cnt;
    almost_full_D1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      #3;
      check_eq($sformatf("bp_stop%0d", i), {30'd0, pop_VC1, pop_VC0}, 32'd0);
    end
    check_eq("bp_inflight_le2", 32'((push_cnt - found) <= 2 ? 1 : 0), 32'd1);
    @(negedge clk);
    almost_full_D1 = 1'b0;
    #3;
    check_eq("bp_hold", 32'(pop_VC0), 32'd0);
    @(negedge clk);
    #3;
    check_eq("bp_resume", 32'(pop_VC0), 32'd1);
    wait_drain(60);
    check_eq("bp_pops", 32'(pop_log.size()), 32'd12);
    check_eq("bp_pushes", 32'(push_cnt - pc), 32'd12);

    // Single entry in VC1, VC0 empty.
    clear_logs();
    pc = push_cnt;
    q1.push_back(6'h1A);
    wait_drain(30);
    check_eq("single_pops", 32'(pop_log.size()), 32'd1);
    if (pop_log.size() > 0) check_eq("single_vc", 32'(pop_log[0]), 32'd1);
    check_eq("single_pushes", 32'(push_cnt - pc), 32'd1);

    // init drop right after a pop: word discarded, starve counter cleared.
    clear_logs();
    for (int i = 0; i < 6; i++) q0.push_back(6'((i * 13 + 2) % 64));
    q1.push_back(6'h3F);
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      @(negedge clk);
      #3;
      if (pop_VC0 || pop_VC1) found = 1;
    end
    check_eq("drop_first_pop", 32'(found), 32'd1);
    @(negedge clk);
    pc = push_cnt;
    init = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      #3;
      check_eq($sformatf("drop_nopop%0d", i), {30'd0, pop_VC1, pop_VC0}, 32'd0);
    end
    check_eq("drop_no_push", 32'(push_cnt - pc), 32'd0);
    check_eq("drop_pop_count", 32'(pop_log.size()), 32'd1);
    if (pop_log.size() > 0) check_eq("drop_pop_vc", 32'(pop_log[0]), 32'd0);
    clear_logs();
    @(negedge clk);
    init = 1'b1;
    wait_drain(60);
    check_eq("drop_resume_len", 32'(pop_log.size()), 32'd6);
    for (int i = 0; i < 6 && i < pop_log.size(); i++)
      check_eq($sformatf("drop_order%0d", i), 32'(pop_log[i]), 32'(order5[i]));

    // Asynchronous reset between clock edges, mid-stream.
    clear_logs();
    for (int i = 0; i < 8; i++) q0.push_back(6'((i * 7 + 33) % 64) | 6'h01);
    tick(5);
    #3;
    reset = 1'b0;
    q0.delete(); q1.delete(); exp_q.delete();
    #1;
    check_eq("arst_push_d0", 32'(push_D0), 32'd0);
    check_eq("arst_push_d1", 32'(push_D1), 32'd0);
    check_eq("arst_data", 32'(data_out), 32'd0);
    check_eq("arst_idle", 32'(idle), 32'd1);
    check_eq("arst_pops", {30'd0, pop_VC1, pop_VC0}, 32'd0);
`ifdef VC_ARB_STATS_EN
    check_eq("arst_fwd0", 32'(fwd_cnt_VC0), 32'd0);
    check_eq("arst_fwd1", 32'(fwd_cnt_VC1), 32'd0);
`endif
    tick(2);
    reset = 1'b1;
    init = 1'b0;
    tick(3);
    check_eq("post_idle", 32'(idle), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
